sys_cmd_ctrl: RTL and testbench

- Parametrised second-generation system controller between UART_RX, RegFile, ALU and the TX FIFO, in the REF_CLK domain.
- Decodes framed UART command bytes and issues RegFile write and read operations and ALU operations.
- Serialises read data and multi-byte ALU results into the TX FIFO.
- Respects FIFO_FULL backpressure.

---
 rtl/sys_cmd_ctrl_if.sv | 33 +++
 rtl/sys_cmd_ctrl.sv | 144 ++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_ctrl_if.sv
// sys_cmd_ctrl_if: UART/RegFile/ALU/TX-FIFO signal bundle around the system command controller
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int ALU_OUT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]    UART_RX_DATA;
  logic                     UART_RX_VLD;
  logic [DATA_WIDTH-1:0]    RF_RdData;
  logic                     RF_RdData_VLD;
  logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
  logic                     ALU_OUT_VLD;
  logic                     FIFO_FULL;
  logic [ADDR_WIDTH-1:0]    RF_Address;
  logic                     RF_WrEn;
  logic                     RF_RdEn;
  logic [DATA_WIDTH-1:0]    RF_WrData;
  logic [ALU_FUN_WIDTH-1:0] ALU_FUN;
  logic                     ALU_EN;
  logic                     CLKG_EN;
  logic [DATA_WIDTH-1:0]    UART_TX_DATA;
  logic                     UART_TX_VLD;
  logic                     CLKDIV_EN;
  modport slave (
    input  UART_RX_DATA, UART_RX_VLD, RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    output RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN, CLKG_EN, UART_TX_DATA, UART_TX_VLD, CLKDIV_EN
  );
  modport master (
    output UART_RX_DATA, UART_RX_VLD, RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN, CLKG_EN, UART_TX_DATA, UART_TX_VLD, CLKDIV_EN
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: decodes UART command frames into RegFile/ALU operations and serialises replies into the TX FIFO.
// Define SYS_CMD_CTRL_ERR_RESP_EN to answer unrecognised command bytes with a single 8'hEE.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] CMD_WR      = 'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD      = 'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 'hDD
) (
  input logic          CLK,
  input logic          RST,
  sys_cmd_ctrl_if.slave bus
);
  localparam int NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] OP_A     = 4'd5;
  localparam logic [3:0] OP_B     = 4'd6;
  localparam logic [3:0] FUN      = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX       = 4'd9;
  logic [3:0]               r_state;
  logic [ADDR_WIDTH-1:0]    r_addr, r_rf_addr;
  logic [DATA_WIDTH-1:0]    r_wr_data, r_tx_data;
  logic [ALU_FUN_WIDTH-1:0] r_alu_fun;
  logic [ALU_OUT_WIDTH-1:0] r_buf;
  logic [CW-1:0]            r_cnt;
  logic                     r_wr_en, r_rd_en, r_alu_en, r_clkg_en, r_tx_vld, r_clkdiv_en;
  logic                     w_vld;
  logic [DATA_WIDTH-1:0]    w_rx;
  assign w_vld = bus.UART_RX_VLD;
  assign w_rx  = bus.UART_RX_DATA;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_rf_addr   <= '0;
      r_wr_data   <= '0;
      r_tx_data   <= '0;
      r_alu_fun   <= '0;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_alu_en    <= 1'b0;
      r_clkg_en   <= 1'b0;
      r_tx_vld    <= 1'b0;
      r_clkdiv_en <= 1'b0;
    end else begin
      r_clkdiv_en <= 1'b1;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_alu_en    <= 1'b0;
      r_tx_vld    <= 1'b0;
      case (r_state)
        IDLE: if (w_vld) begin
          if (w_rx == CMD_WR) r_state <= WR_ADDR;
          else if (w_rx == CMD_RD) r_state <= RD_ADDR;
          else if (w_rx == CMD_ALU_OP) r_state <= OP_A;
          else if (w_rx == CMD_ALU_NOP) r_state <= FUN;
`ifdef SYS_CMD_CTRL_ERR_RESP_EN
          else begin
            r_buf   <= ALU_OUT_WIDTH'(8'hEE);
            r_cnt   <= CW'(1);
            r_state <= TX;
          end
`endif
        end
        WR_ADDR: if (w_vld) begin
          r_addr  <= w_rx[ADDR_WIDTH-1:0];
          r_state <= WR_DATA;
        end
        WR_DATA: if (w_vld) begin
          r_wr_en   <= 1'b1;
          r_rf_addr <= r_addr;
          r_wr_data <= w_rx;
          r_state   <= IDLE;
        end
        RD_ADDR: if (w_vld) begin
          r_rd_en   <= 1'b1;
          r_rf_addr <= w_rx[ADDR_WIDTH-1:0];
          r_state   <= RD_WAIT;
        end
        RD_WAIT: if (bus.RF_RdData_VLD) begin
          r_buf   <= ALU_OUT_WIDTH'(bus.RF_RdData);
          r_cnt   <= CW'(1);
          r_state <= TX;
        end
        OP_A: if (w_vld) begin
          r_wr_en   <= 1'b1;
          r_rf_addr <= '0;
          r_wr_data <= w_rx;
          r_state   <= OP_B;
        end
        OP_B: if (w_vld) begin
          r_wr_en   <= 1'b1;
          r_rf_addr <= ADDR_WIDTH'(1);
          r_wr_data <= w_rx;
          r_state   <= FUN;
        end
        FUN: if (w_vld) begin
          r_alu_en  <= 1'b1;
          r_alu_fun <= w_rx[ALU_FUN_WIDTH-1:0];
          r_clkg_en <= 1'b1;
          r_state   <= ALU_WAIT;
        end
        ALU_WAIT: if (bus.ALU_OUT_VLD) begin
          r_buf     <= bus.ALU_OUT;
          r_cnt     <= CW'(NBYTES);
          r_clkg_en <= 1'b0;
          r_state   <= TX;
        end
        TX: begin
          // data tracks the pending byte even while the FIFO stalls us
          r_tx_data <= r_buf[DATA_WIDTH-1:0];
          if (!bus.FIFO_FULL) begin
            r_tx_vld <= 1'b1;
            r_buf    <= r_buf >> DATA_WIDTH;
            r_cnt    <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.RF_Address   = r_rf_addr;
  assign bus.RF_WrEn      = r_wr_en;
  assign bus.RF_RdEn      = r_rd_en;
  assign bus.RF_WrData    = r_wr_data;
  assign bus.ALU_FUN      = r_alu_fun;
  assign bus.ALU_EN       = r_alu_en;
  assign bus.CLKG_EN      = r_clkg_en;
  assign bus.UART_TX_DATA = r_tx_data;
  assign bus.UART_TX_VLD  = r_tx_vld;
  assign bus.CLKDIV_EN    = r_clkdiv_en;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: table-driven command frames with scoreboards for RegFile writes/reads, ALU starts and TX bytes
module tb_sys_cmd_ctrl;
  typedef struct {
    logic [31:0] b;
    int          n;
    logic [7:0]  rd;
    logic [15:0] alu;
    int          nwr;
    logic [11:0] w0;
    logic [11:0] w1;
    int          nrd;
    logic [3:0]  ra;
    int          nalu;
    logic [3:0]  fun;
    int          ntx;
    logic [15:0] tx;
    bit          err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]  rd_val = 8'h00;
  logic [15:0] alu_val = 16'h0000;
  logic [7:0]  tx_q[$];
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  vec_t vecs[8];
  sys_cmd_ctrl_if bus();
  sys_cmd_ctrl dut (.CLK(clk), .RST(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.UART_RX_DATA = b;
    bus.UART_RX_VLD = 1'b1;
    @(negedge clk);
    bus.UART_RX_VLD = 1'b0;
  endtask
  task automatic drain();
    int i = 0;
    while ((tx_q.size() + wr_q.size() + rd_q.size() + alu_q.size()) != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("drain_pending", 32'(tx_q.size() + wr_q.size() + rd_q.size() + alu_q.size()), 0);
    repeat (6) @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_strobes"}, {bus.RF_WrEn, bus.RF_RdEn, bus.ALU_EN, bus.CLKG_EN, bus.UART_TX_VLD}, 0);
    chk({tag, "_addr"}, bus.RF_Address, 0);
    chk({tag, "_wrdata"}, bus.RF_WrData, 0);
    chk({tag, "_fun"}, bus.ALU_FUN, 0);
    chk({tag, "_txdata"}, bus.UART_TX_DATA, 0);
    chk({tag, "_clkdiv"}, bus.CLKDIV_EN, 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (bus.UART_TX_VLD === 1'b1) begin
      chk("tx_expected", tx_q.size() != 0, 1);
      if (tx_q.size() != 0) chk("tx_data", bus.UART_TX_DATA, tx_q.pop_front());
    end
    if (bus.RF_WrEn === 1'b1) begin
      chk("wr_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) chk("wr_addr_data", {bus.RF_Address, bus.RF_WrData}, wr_q.pop_front());
    end
    if (bus.RF_RdEn === 1'b1) begin
      chk("rd_expected", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) chk("rd_addr", bus.RF_Address, rd_q.pop_front());
    end
    if (bus.ALU_EN === 1'b1) begin
      chk("alu_expected", alu_q.size() != 0, 1);
      if (alu_q.size() != 0) chk("alu_fun", bus.ALU_FUN, alu_q.pop_front());
      chk("clkg_with_alu_en", bus.CLKG_EN, 1);
    end
  end
  initial begin
    bus.RF_RdData = 8'h00;
    bus.RF_RdData_VLD = 1'b0;
    bus.ALU_OUT = 16'h0000;
    bus.ALU_OUT_VLD = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.RF_RdEn === 1'b1) begin
        @(negedge clk);
        bus.RF_RdData = rd_val;
        bus.RF_RdData_VLD = 1'b1;
        @(negedge clk);
        bus.RF_RdData_VLD = 1'b0;
      end else if (bus.ALU_EN === 1'b1) begin
        bus.ALU_OUT = alu_val;
        bus.ALU_OUT_VLD = 1'b1;
        @(negedge clk);
        bus.ALU_OUT_VLD = 1'b0;
      end
    end
  end
  initial begin
    vec_t v;
    int i;
    bus.UART_RX_DATA = 8'h00;
    bus.UART_RX_VLD = 1'b0;
    bus.FIFO_FULL = 1'b0;
    vecs = '{
      '{32'hAA053C00, 3, 8'h00, 16'h0000, 1, 12'h53C, 12'h000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1'b0},
      '{32'hBB050000, 2, 8'h3C, 16'h0000, 0, 12'h000, 12'h000, 1, 4'h5, 0, 4'h0, 1, 16'h003C, 1'b0},
      '{32'hCC123400, 4, 8'h00, 16'h0446, 2, 12'h012, 12'h134, 0, 4'h0, 1, 4'h0, 2, 16'h0446, 1'b0},
      '{32'hDD020000, 2, 8'h00, 16'hFFEE, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'h2, 2, 16'hFFEE, 1'b0},
      '{32'hAA0FA500, 3, 8'h00, 16'h0000, 1, 12'hFA5, 12'h000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1'b0},
      '{32'hBB1A0000, 2, 8'h81, 16'h0000, 0, 12'h000, 12'h000, 1, 4'hA, 0, 4'h0, 1, 16'h0081, 1'b0},
      '{32'hDD1F0000, 2, 8'h00, 16'h8001, 0, 12'h000, 12'h000, 0, 4'h0, 1, 4'hF, 2, 16'h8001, 1'b0},
      '{32'h7E000000, 1, 8'h00, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1'b1}
    };
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("clkdiv_after_reset", bus.CLKDIV_EN, 1);
    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      rd_val = v.rd;
      alu_val = v.alu;
      if (v.nwr > 0) wr_q.push_back(v.w0);
      if (v.nwr > 1) wr_q.push_back(v.w1);
      if (v.nrd > 0) rd_q.push_back(v.ra);
      if (v.nalu > 0) alu_q.push_back(v.fun);
      for (int j = 0; j < v.ntx; j++) tx_q.push_back(v.tx[8*j +: 8]);
`ifdef SYS_CMD_CTRL_ERR_RESP_EN
      if (v.err) tx_q.push_back(8'hEE);
`endif
      for (int j = 0; j < v.n; j++) begin
        send_byte(v.b[31-8*j -: 8]);
        @(negedge clk);
      end
      drain();
    end
    // back-to-back: BB lands on the first cycle back in IDLE after the write
    rd_val = 8'h99;
    wr_q.push_back(12'h53C);
    rd_q.push_back(4'h7);
    tx_q.push_back(8'h99);
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    send_byte(8'hBB);
    send_byte(8'h07);
    drain();
    bus.FIFO_FULL = 1'b1;
    alu_val = 16'hFFEE;
    alu_q.push_back(4'h2);
    tx_q.push_back(8'hEE);
    tx_q.push_back(8'hFF);
    send_byte(8'hDD);
    @(negedge clk);
    send_byte(8'h02);
    i = 0;
    while (bus.CLKG_EN !== 1'b1 && i < 50) begin @(negedge clk); i++; end
    chk("full_clkg_rise", bus.CLKG_EN, 1);
    i = 0;
    while (bus.CLKG_EN !== 1'b0 && i < 50) begin @(negedge clk); i++; end
    chk("full_clkg_fall", bus.CLKG_EN, 0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("full_no_vld", bus.UART_TX_VLD, 0);
      chk("full_hold_data", bus.UART_TX_DATA, 8'hEE);
    end
    chk("full_tx_pending", 32'(tx_q.size()), 2);
    bus.FIFO_FULL = 1'b0;
    drain();
    wr_q.push_back(12'h012);
    send_byte(8'hCC);
    @(negedge clk);
    send_byte(8'h12);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_clkdiv", bus.CLKDIV_EN, 1);
    chk("midrst_opa_write_seen", 32'(wr_q.size()), 0);
    wr_q.push_back(12'h155);
    send_byte(8'hAA);
    @(negedge clk);
    send_byte(8'h01);
    @(negedge clk);
    send_byte(8'h55);
    @(negedge clk);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
